// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_D,
        RESP_I,
        RESP_D
    } state_t;

    localparam logic [3:0] WE_NONE = 4'b0000;

    // Read data returned to a requester whose access was aborted by the watchdog.
    localparam int unsigned ABORT_DATA = 0;

endpackage

// File: rtl/arb_timer.sv
// rtl/arb_timer.sv - grant watchdog counter with terminal-count flag
//
// Purpose: counts cycles spent waiting on memory inside a grant state.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   clear  - synchronous clear (held while the arbiter is idle)
//   enable - count one cycle
//   tc     - count has reached TIMEOUT-1
module arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign tc = (count == CW'(TIMEOUT - 1));

    // Holds at terminal count; the arbiter leaves the grant state on that cycle anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a shared single-port memory
//
// Purpose: grants one memory access at a time to either the fetch port or the
// data port. Data wins ties unless it has already taken DATA_STREAK grants in
// a row while fetch was waiting. A watchdog aborts accesses that never see
// mem_ready and sets a sticky err flag.
// Ports:
//   clk, rstd                        - clock, asynchronous active-high reset
//   if_req/if_addr/if_ack/if_rdata   - fetch read port
//   dm_req/dm_we/dm_addr/dm_wdata/dm_ack/dm_rdata - data load/store port
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready - memory side
//   stall                            - hold pc while a request is outstanding
//   err                              - sticky watchdog timeout flag
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DATA_STREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              err
);

    localparam int SW = $clog2(DATA_STREAK + 1);

    state_t            state;
    logic [SW-1:0]     streak;
    logic              streak_full;
    logic              in_gnt;
    logic              tmr_tc;
    logic [DATA_W-1:0] resp_data;

    assign streak_full = (streak == SW'(DATA_STREAK));
    assign in_gnt      = (state == GNT_I) || (state == GNT_D);

    // Acks are registered, so stall drops in the same cycle the ack is visible.
    assign stall = ~rstd & (if_req | dm_req) & ~(if_ack | dm_ack);

    // Stores and aborted accesses return zero rather than whatever the bus holds.
    always_comb begin
        resp_data = mem_rdata;
        if (!mem_ready) begin
            resp_data = DATA_W'(ABORT_DATA);
        end else if (mem_we != WE_NONE) begin
            resp_data = '0;
        end
    end

    arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rstd),
        .clear (state == IDLE),
        .enable(in_gnt && !mem_ready),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            state     <= IDLE;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= WE_NONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_req && !(if_req && streak_full)) begin
                        state     <= GNT_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        // Only grants taken while fetch is waiting count toward starvation.
                        if (!if_req) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (if_req) begin
                        state     <= GNT_I;
                        mem_req   <= 1'b1;
                        mem_we    <= WE_NONE;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        streak    <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_ready || tmr_tc) begin
                        mem_req <= 1'b0;
                        if (!mem_ready) begin
                            err <= 1'b1;
                        end
                        if (state == GNT_I) begin
                            state    <= RESP_I;
                            if_ack   <= 1'b1;
                            if_rdata <= resp_data;
                        end else begin
                            state    <= RESP_D;
                            dm_ack   <= 1'b1;
                            dm_rdata <= resp_data;
                        end
                    end
                end
                RESP_I, RESP_D: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } txn_t;

    typedef struct {
        logic [31:0] exp;
        int          cyc;
        int          lat;
    } sb_t;

    logic        clk = 1'b0;
    logic        rstd;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    txn_t dm_pend[$];
    txn_t if_pend[$];
    sb_t  dm_sb[$];
    sb_t  if_sb[$];
    byte  order[$];

    bit   dm_busy;
    bit   if_busy;
    bit   dm_abort = 1'b0;
    int   mem_lat = 0;
    bit   never_ready = 1'b0;
    int   last_run = 0;

    logic [31:0] mem_arr [0:255];

    mem_arbiter dut (
        .clk      (clk),
        .rstd     (rstd),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall    (stall),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_dm(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                           input logic [31:0] exp, input int lat);
        txn_t t;
        t.addr = a; t.we = we; t.wdata = wd; t.exp = exp; t.lat = lat;
        dm_pend.push_back(t);
    endtask

    task automatic push_if(input logic [31:0] a, input logic [31:0] exp, input int lat);
        txn_t t;
        t.addr = a; t.we = 4'b0000; t.wdata = '0; t.exp = exp; t.lat = lat;
        if_pend.push_back(t);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((dm_pend.size() > 0 || if_pend.size() > 0 || dm_busy || if_busy ||
                dm_sb.size() > 0 || if_sb.size() > 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("idle_wait", 0, 1);
    endtask

    task automatic wait_mem_req();
        int n = 0;
        while (!mem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) check("mem_req_wait", 0, 1);
    endtask

    // Memory model: ready after mem_lat wait cycles, byte-enable writes applied on ready.
    initial begin : mem_model
        int cnt = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = pat(i * 4);
        mem_arr[8'h40] = 32'hDEADBEEF;
        mem_ready = 1'b0;
        mem_rdata = 32'hCAFEF00D;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !never_ready && cnt >= mem_lat) begin
                mem_ready = 1'b1;
                if (mem_we == 4'b0000) begin
                    mem_rdata = mem_arr[mem_addr[9:2]];
                end else begin
                    mem_rdata = 32'hBAD0BAD0;
                    for (int b = 0; b < 4; b++)
                        if (mem_we[b]) mem_arr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hCAFEF00D;
            end
            if (mem_req) cnt++;
            else cnt = 0;
        end
    end

    initial begin : dm_agent
        txn_t t;
        sb_t  s;
        int   n;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_busy = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dm_pend.size() > 0) begin
                t = dm_pend.pop_front();
                dm_req = 1; dm_we = t.we; dm_addr = t.addr; dm_wdata = t.wdata; dm_busy = 1;
                s.exp = t.exp; s.cyc = cyc; s.lat = t.lat;
                dm_sb.push_back(s);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!dm_ack && !dm_abort && n < 200);
                if (dm_abort) begin
                    void'(dm_sb.pop_back());
                    dm_req = 0;
                    dm_busy = 0;
                end else if (!dm_ack) begin
                    check("dm_ack_wait", 0, 1);
                    void'(dm_sb.pop_back());
                end
            end else begin
                dm_req = 0;
                dm_busy = 0;
            end
        end
    end

    initial begin : if_agent
        txn_t t;
        sb_t  s;
        int   n;
        if_req = 0; if_addr = 0; if_busy = 0;
        forever begin
            @(posedge clk);
            #1;
            if (if_pend.size() > 0) begin
                t = if_pend.pop_front();
                if_req = 1; if_addr = t.addr; if_busy = 1;
                s.exp = t.exp; s.cyc = cyc; s.lat = t.lat;
                if_sb.push_back(s);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!if_ack && n < 200);
                if (!if_ack) begin
                    check("if_ack_wait", 0, 1);
                    void'(if_sb.pop_back());
                end
            end else begin
                if_req = 0;
                if_busy = 0;
            end
        end
    end

    // Scoreboard: pop on each ack, check data, latency and that rdata holds between acks.
    initial begin : monitor
        sb_t e;
        int run = 0;
        logic [31:0] last_dm = '0;
        logic [31:0] last_if = '0;
        forever begin
            @(negedge clk);
            if (rstd) begin
                run = 0;
                last_dm = '0;
                last_if = '0;
            end else begin
                if (mem_req) run++;
                else if (run > 0) begin
                    last_run = run;
                    run = 0;
                end
                if (dm_ack && if_ack) check("dual_ack", 1, 0);
                if (dm_ack) begin
                    if (dm_sb.size() == 0) check("dm_ack_spurious", 1, 0);
                    else begin
                        e = dm_sb.pop_front();
                        check("dm_rdata", dm_rdata, e.exp);
                        if (e.lat >= 0) check("dm_latency", cyc - e.cyc, e.lat);
                        last_dm = e.exp;
                        order.push_back("D");
                    end
                end else begin
                    check("dm_rdata_hold", dm_rdata, last_dm);
                end
                if (if_ack) begin
                    if (if_sb.size() == 0) check("if_ack_spurious", 1, 0);
                    else begin
                        e = if_sb.pop_front();
                        check("if_rdata", if_rdata, e.exp);
                        if (e.lat >= 0) check("if_latency", cyc - e.cyc, e.lat);
                        last_if = e.exp;
                        order.push_back("I");
                    end
                end else begin
                    check("if_rdata_hold", if_rdata, last_if);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        string       exp_ord;
        logic [31:0] p;
        int          n;

        rstd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_dm_ack", dm_ack, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_stall", stall, 0);
        check("rst_err", err, 0);
        rstd = 1'b0;
        repeat (2) @(negedge clk);

        // Single load, memory ready on the first grant cycle.
        @(posedge clk); #2;
        push_dm(32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 2);
        @(posedge clk);
        @(negedge clk);
        check("ld_c0_stall", stall, 1);
        check("ld_c0_mem_req", mem_req, 0);
        @(negedge clk);
        check("ld_c1_mem_req", mem_req, 1);
        check("ld_c1_mem_addr", mem_addr, 32'h100);
        check("ld_c1_mem_we", mem_we, 0);
        check("ld_c1_stall", stall, 1);
        @(negedge clk);
        check("ld_c2_dm_ack", dm_ack, 1);
        check("ld_c2_dm_rdata", dm_rdata, 32'hDEADBEEF);
        check("ld_c2_stall", stall, 0);
        check("ld_c2_mem_req", mem_req, 0);
        wait_idle();

        // Store with wait states: bus held stable across all grant cycles.
        @(posedge clk); #2;
        mem_lat = 2;
        push_dm(32'h200, 4'b0011, 32'h12345678, 32'h0, 4);
        wait_mem_req();
        for (int k = 0; k < 3; k++) begin
            check("st_mem_req", mem_req, 1);
            check("st_mem_we", mem_we, 4'b0011);
            check("st_mem_addr", mem_addr, 32'h200);
            check("st_mem_wdata", mem_wdata, 32'h12345678);
            @(negedge clk);
        end
        check("st_dm_ack", dm_ack, 1);
        check("st_mem_req_off", mem_req, 0);
        wait_idle();

        // Read back the partially written word, then a plain fetch.
        @(posedge clk); #2;
        mem_lat = 0;
        p = pat(32'h200);
        push_dm(32'h200, 4'b0000, 32'h0, {p[31:16], 16'h5678}, 2);
        push_if(32'h010, pat(32'h010), -1);
        wait_idle();

        // Simultaneous requests with streak 0: data first.
        @(posedge clk); #2;
        order.delete();
        push_dm(32'h104, 4'b0000, 32'h0, pat(32'h104), -1);
        push_if(32'h014, pat(32'h014), -1);
        wait_idle();
        exp_ord = "DI";
        check("simul_len", order.size(), exp_ord.len());
        for (int i = 0; i < order.size() && i < exp_ord.len(); i++)
            check("simul_order", order[i], exp_ord[i]);

        // Starvation: both held continuously, fetch gets every fifth grant.
        @(posedge clk); #2;
        order.delete();
        for (int i = 0; i < 6; i++) push_dm(32'h108 + 4 * i, 4'b0000, 32'h0, pat(32'h108 + 4 * i), -1);
        push_if(32'h020, pat(32'h020), -1);
        push_if(32'h024, pat(32'h024), -1);
        wait_idle();
        exp_ord = "DDDDIDDI";
        check("starve_len", order.size(), exp_ord.len());
        for (int i = 0; i < order.size() && i < exp_ord.len(); i++)
            check("starve_order", order[i], exp_ord[i]);

        // Timeout: memory never ready on a fetch.
        check("pre_to_err", err, 0);
        @(posedge clk); #2;
        never_ready = 1'b1;
        push_if(32'h030, 32'h0, 65);
        wait_idle();
        check("to_mem_req_len", last_run, 64);
        check("to_err", err, 1);
        @(posedge clk); #2;
        never_ready = 1'b0;
        push_dm(32'h140, 4'b0000, 32'h0, pat(32'h140), 2);
        wait_idle();
        check("to_err_sticky", err, 1);

        // Reset in the middle of a data grant.
        @(posedge clk); #2;
        never_ready = 1'b1;
        push_dm(32'h144, 4'b0000, 32'h0, 32'h0, -1);
        wait_mem_req();
        repeat (3) @(negedge clk);
        #2;
        dm_abort = 1'b1;
        rstd = 1'b1;
        #1;
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_err", err, 0);
        @(negedge clk);
        #2;
        rstd = 1'b0;
        n = 0;
        while (dm_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (dm_busy) check("abort_wait", 0, 1);
        dm_abort = 1'b0;
        never_ready = 1'b0;
        @(posedge clk); #2;
        push_dm(32'h148, 4'b0000, 32'h0, pat(32'h148), 2);
        wait_idle();
        check("post_rst_err", err, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage (instruction reads) and the data-memory stage (loads/stores with 4-bit byte enables).
- Sits between fetch/data_mem and the memory model; drives a stall to the pc so the program counter holds while an access is outstanding.
- Data port has priority, with anti-starvation for fetch.
- A timeout watchdog aborts hung memory transactions and raises a sticky error.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- DATA_STREAK, 4, maximum consecutive data grants while if_req is waiting; the next grant goes to fetch
- TIMEOUT, 64, maximum cycles in a grant state without mem_ready before abort (≥2)

Ports:
- clk  in  1  system clock, rising edge
- rstd  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  instruction; valid while if_ack=1
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  4  byte write enables; 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ack  out  1  one-cycle completion pulse
- dm_rdata  out  DATA_W  load data; valid while dm_ack=1
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  4  byte enables to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready
- mem_ready  in  1  memory completes the access this cycle
- stall  out  1  hold pc/pipeline
- err  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; streak and timer counters 0; err cleared. Asserting rstd mid-transaction drops mem_req immediately and discards the transaction; no ack follows.
- States:
  - IDLE: choose a winner if any request is pending.
  - GNT_I / GNT_D: memory access in flight.
  - RESP_I / RESP_D: acknowledge the requester.
- IDLE, arbitration:
  - dm_req only → GNT_D.
  - if_req only → GNT_I.
  - Both → GNT_D, unless streak==DATA_STREAK, then GNT_I.
  - On the transition, latch addr/we/wdata into registers. Fetch grants force mem_we=0.
- Streak counter:
  - Increments on a GNT_D entry while if_req=1.
  - Clears on a GNT_I entry, or on a GNT_D entry with if_req=0.
  - Saturates at DATA_STREAK.
- GNT_x:
  - mem_req=1 and mem_* driven from the latched registers, stable until exit.
  - mem_ready=1 → capture mem_rdata (or 0 when latched we≠0) into the port's rdata register; go to RESP_x.
  - Otherwise the timer increments. Timer reaching TIMEOUT-1 with mem_ready=0 → set err, capture rdata=0, go to RESP_x (abort).
  - The timer clears on every GNT entry.
- RESP_x: the matching ack=1 for exactly one cycle, rdata valid; mem_req=0; next state IDLE. A new request can be granted on the following IDLE cycle.
- Latency: request seen in IDLE at cycle 0 → mem_req cycles 1..k (k = first mem_ready cycle) → ack at k+1. Minimum 2 cycles to ack; a back-to-back request is granted at k+2.
- rdata registers hold their value between acks.
- stall = (if_req | dm_req) & ~(if_ack | dm_ack); forced 0 while rstd=1.
- A requester deasserting req after its grant is a protocol violation. The transaction still completes and ack still pulses.
- err stays 1 until reset; the arbiter keeps operating normally after setting it.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, GNT_I, GNT_D, RESP_I, RESP_D)
  - WE_NONE = 4'b0000
  - ABORT_DATA = 0
- Sub-module arb_timer:
  - clear/enable counter with a terminal-count output for TIMEOUT.
  - The streak counter stays inline.

Test Plan:
- Single load: dm_req=1, dm_addr=0x100, dm_we=0, memory ready in the same cycle as mem_req, mem_rdata=0xDEADBEEF → mem_req cycle 1 with addr 0x100; dm_ack and dm_rdata=0xDEADBEEF at cycle 2; stall=1 for cycles 0–1.
- Store with wait states: dm_we=4'b0011, dm_wdata=0x12345678, mem_ready delayed 3 cycles → mem_we/addr/wdata stable for 3 cycles; dm_ack one cycle later; dm_rdata=0.
- Starvation: if_req and dm_req both held continuously, DATA_STREAK=4 → grant order D,D,D,D,I,D,…; every if_ack carries the correct fetch data.
- Simultaneous requests with streak 0 → data granted first; if_ack arrives only after dm_ack.
- Timeout: memory never ready, TIMEOUT=64 → mem_req high for 64 cycles; then if_ack with if_rdata=0; err=1 and sticky; the next access completes normally.
- Reset mid-GNT_D: assert rstd for one cycle → mem_req drops asynchronously; no dm_ack; err=0; the next request is served from IDLE.
